addsub_rr_sched: RTL

Round-robin scheduler that shares one combinational adder and one combinational subtractor (32-bit, a+b -> sum, x-y -> sub) between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake, drives the shared units from registers, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between client blocks and the shared arithmetic datapath.

---
 rtl/addsub_rr_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one adder and one subtractor among NUM_REQ requesters.
// Define ADDSUB_SCHED_OVF_EN to build the signed-overflow flag on rsp_ovf; otherwise it is tied to 0.
module addsub_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [DATA_W-1:0]         a,
    output logic [DATA_W-1:0]         b,
    input  logic [DATA_W-1:0]         sum,
    output logic [DATA_W-1:0]         x,
    output logic [DATA_W-1:0]         y,
    input  logic [DATA_W-1:0]         sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_ovf
);

    localparam int SW = ID_W + 2;
    localparam logic [SW-1:0]      SW_ONE   = SW'(1'b1);
    localparam logic [SW-1:0]      SW_NREQ  = SW'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] OH_LSB   = NUM_REQ'(1'b1);
    localparam logic [ID_W-1:0]    PTR_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ID_W-1:0]       ptr_r;
    logic [ID_W-1:0]       id_r;
    logic                  op_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic [DATA_W-1:0]     x_r;
    logic [DATA_W-1:0]     y_r;
    logic                  rsp_valid_r;
    logic [ID_W-1:0]       rsp_id_r;
    logic [DATA_W-1:0]     rsp_data_r;

    logic [2*NUM_REQ-1:0]  dbl_s;
    logic [NUM_REQ-1:0]    rot_s;
    logic [NUM_REQ-1:0]    grant_oh_s;
    logic [SW-1:0]         off_s;
    logic [SW-1:0]         pos_s;
    logic [ID_W-1:0]       grant_id_s;
    logic                  grant_vld_s;
    logic                  acc_s;
    logic                  sel_op_s;
    logic [DATA_W-1:0]     sel_a_s;
    logic [DATA_W-1:0]     sel_b_s;
    logic [DATA_W-1:0]     result_s;

    // Rotate the valid vector so bit 0 is the requester just after ptr, then take the lowest set bit.
    always_comb begin
        dbl_s       = {req_valid, req_valid};
        rot_s       = NUM_REQ'(dbl_s >> (SW'(ptr_r) + SW_ONE));
        grant_vld_s = |rot_s;
        off_s       = {SW{1'b0}};
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? SW'(j) : off_s;
        end
        pos_s       = SW'(ptr_r) + SW_ONE + off_s;
        grant_id_s  = (pos_s >= SW_NREQ) ? ID_W'(pos_s - SW_NREQ) : ID_W'(pos_s);
        grant_oh_s  = grant_vld_s ? (OH_LSB << grant_id_s) : {NUM_REQ{1'b0}};
        acc_s       = rst_n && (state_r == IDLE) && grant_vld_s;
    end

    // Select the winning requester's op and operands.
    always_comb begin
        sel_op_s = 1'b0;
        sel_a_s  = {DATA_W{1'b0}};
        sel_b_s  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_op_s = (grant_id_s == ID_W'(i)) ? req_op[i]                  : sel_op_s;
            sel_a_s  = (grant_id_s == ID_W'(i)) ? req_a[i*DATA_W +: DATA_W] : sel_a_s;
            sel_b_s  = (grant_id_s == ID_W'(i)) ? req_b[i*DATA_W +: DATA_W] : sel_b_s;
        end
        result_s = op_r ? sub : sum;
    end

    assign req_ready = acc_s ? grant_oh_s : {NUM_REQ{1'b0}};

    // Next-state logic: one accepted op walks IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = acc_s ? EXEC : IDLE;
            EXEC:    state_nxt_s = RESP;
            RESP:    state_nxt_s = rsp_ready ? IDLE : RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the accepted op; only the pair for the chosen unit is reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
            id_r <= {ID_W{1'b0}};
            a_r  <= {DATA_W{1'b0}};
            b_r  <= {DATA_W{1'b0}};
            x_r  <= {DATA_W{1'b0}};
            y_r  <= {DATA_W{1'b0}};
        end else if (acc_s) begin
            op_r <= sel_op_s;
            id_r <= grant_id_s;
            if (sel_op_s) begin
                x_r <= sel_a_s;
                y_r <= sel_b_s;
            end else begin
                a_r <= sel_a_s;
                b_r <= sel_b_s;
            end
        end
    end

    // Response registers and round-robin pointer; pointer moves only once the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            ptr_r       <= PTR_INIT;
        end else begin
            case (state_r)
                EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_data_r  <= result_s;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ptr_r       <= id_r;
                    end
                end
                default: rsp_valid_r <= rsp_valid_r;
            endcase
        end
    end

`ifdef ADDSUB_SCHED_OVF_EN
    logic rsp_ovf_r;

    function automatic logic ovf_calc(input logic is_sub, input logic [DATA_W-1:0] p,
                                      input logic [DATA_W-1:0] q, input logic [DATA_W-1:0] r);
        logic same_sign;
        same_sign = (p[DATA_W-1] == q[DATA_W-1]);
        return (is_sub ? !same_sign : same_sign) && (r[DATA_W-1] != p[DATA_W-1]);
    endfunction

    // Signed overflow is captured alongside rsp_data and held with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf_r <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_ovf_r <= ovf_calc(op_r, op_r ? x_r : a_r, op_r ? y_r : b_r, result_s);
        end
    end

    assign rsp_ovf = rsp_ovf_r;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign a         = a_r;
    assign b         = b_r;
    assign x         = x_r;
    assign y         = y_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule
